// File: rtl/wb_ram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-RAM bridge.
package wb_ram_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
   localparam logic [31:0] DEF_WIN_MASK  = 32'hFFFF_F000;

   function automatic logic win_hit(input logic [31:0] adr,
                                    input logic [31:0] mask,
                                    input logic [31:0] base);
      return ((adr & mask) == base);
   endfunction

endpackage

// File: rtl/wb_ram_bridge_if.sv
// Wishbone slave-side bus bundle for the RAM bridge.
interface wb_ram_bridge_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_ram_bridge_timer.sv
// Saturating wait counter; o_done flags that this cycle's increment reaches TIMEOUT.
module wb_ram_bridge_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic i_clr,
   input  logic i_en,
   output logic o_done
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   // wait counter: clear on entry to WAIT, count while waiting, hold at TIMEOUT
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // done when the count about to be reached equals TIMEOUT
   always_comb begin
      o_done = (r_cnt >= LAST);
   end

endmodule

// File: rtl/wb_ram_bridge.sv
// Bridges a Wishbone slave window onto a single-port RAM request/rvalid port.
module wb_ram_bridge
   import wb_ram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter logic [31:0] WIN_MASK   = DEF_WIN_MASK,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   wb_ram_bridge_if.slave        wb,
   output logic                  ext_data_req_o,
   output logic [ADDR_WIDTH-1:0] ext_data_addr_o,
   output logic                  ext_data_we_o,
   output logic [3:0]            ext_data_be_o,
   output logic [31:0]           ext_data_wdata_o,
   input  logic [31:0]           ext_data_rdata_i,
   input  logic                  ext_data_rvalid_i,
   output logic                  timeout_err_o
);

   state_e r_state;
   state_e w_next;

   logic                  w_sel;
   logic                  w_accept;
   logic                  w_rsp;
   logic                  w_tmo;
   logic                  w_tmr_done;
   logic                  w_tmr_clr;
   logic                  w_tmr_en;

   logic                  r_req;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [3:0]            r_be;
   logic [31:0]           r_wdata;
   logic                  r_drop;
   logic                  r_ack;
   logic [31:0]           r_dat;
   logic                  r_err;

   // window decode on the live bus
   always_comb begin
      w_sel = wb.wbs_cyc_i & wb.wbs_stb_i & win_hit(wb.wbs_adr_i, WIN_MASK, BASE_ADDR);
   end

   // state register
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state and transition strobes
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_rsp     = 1'b0;
      w_tmo     = 1'b0;
      w_tmr_clr = 1'b0;
      w_tmr_en  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel) begin
               w_next   = ST_ISSUE;
               w_accept = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_next    = ST_WAIT;
            w_tmr_clr = 1'b1;
         end
         ST_WAIT: begin
            w_tmr_en = 1'b1;
            if (ext_data_rvalid_i) begin
               w_next = ST_ACK;
               w_rsp  = 1'b1;
            end else if (w_tmr_done) begin
               w_next = ST_ACK;
               w_tmo  = 1'b1;
            end else begin
               w_next = ST_WAIT;
            end
         end
         ST_ACK: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   wb_ram_bridge_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_ni (rst_ni),
      .i_clr  (w_tmr_clr),
      .i_en   (w_tmr_en),
      .o_done (w_tmr_done)
   );

   // request fields captured at acceptance and held for the RAM port
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= 4'h0;
         r_wdata <= 32'h0000_0000;
      end else if (w_accept) begin
         r_req   <= 1'b1;
         r_addr  <= wb.wbs_adr_i[ADDR_WIDTH+1:2];
         r_we    <= wb.wbs_we_i;
         r_be    <= wb.wbs_sel_i;
         r_wdata <= wb.wbs_dat_i;
      end else begin
         r_req   <= 1'b0;
         r_addr  <= r_addr;
         r_we    <= r_we;
         r_be    <= r_be;
         r_wdata <= r_wdata;
      end
   end

   // a master that abandons the cycle mid-flight still lets the RAM finish, but gets no ack
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_drop <= 1'b0;
      end else if (w_accept) begin
         r_drop <= 1'b0;
      end else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !wb.wbs_cyc_i) begin
         r_drop <= 1'b1;
      end else begin
         r_drop <= r_drop;
      end
   end

   // registered response: ack pulse, read data and sticky timeout flag
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ack <= 1'b0;
         r_dat <= 32'h0000_0000;
         r_err <= 1'b0;
      end else begin
         r_ack <= (w_rsp | w_tmo) & wb.wbs_cyc_i & ~r_drop;
         if (w_tmo) begin
            r_dat <= TIMEOUT_DATA;
            r_err <= 1'b1;
         end else if (w_rsp && !r_we) begin
            r_dat <= ext_data_rdata_i;
            r_err <= r_err;
         end else begin
            r_dat <= r_dat;
            r_err <= r_err;
         end
      end
   end

   assign ext_data_req_o   = r_req;
   assign ext_data_addr_o  = r_addr;
   assign ext_data_we_o    = r_we;
   assign ext_data_be_o    = r_be;
   assign ext_data_wdata_o = r_wdata;
   assign wb.wbs_ack_o     = r_ack;
   assign wb.wbs_dat_o     = r_dat;
   assign timeout_err_o    = r_err;

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge with a one-cycle-latency RAM model.
module tb_wb_ram_bridge;

   logic        clk;
   logic        rst_ni;
   logic        req;
   logic [9:0]  addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;
   logic        stuck;
   logic [31:0] mem [0:1023];

   int n_chk;
   int n_fail;

   wb_ram_bridge_if wb ();

   wb_ram_bridge #(
      .ADDR_WIDTH (10),
      .BASE_ADDR  (32'h3000_0000),
      .WIN_MASK   (32'hFFFF_F000),
      .TIMEOUT    (15)
   ) dut (
      .clk               (clk),
      .rst_ni            (rst_ni),
      .wb                (wb),
      .ext_data_req_o    (req),
      .ext_data_addr_o   (addr),
      .ext_data_we_o     (we),
      .ext_data_be_o     (be),
      .ext_data_wdata_o  (wdata),
      .ext_data_rdata_i  (rdata),
      .ext_data_rvalid_i (rvalid),
      .timeout_err_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: answers every request one cycle later; reset reloads the preset words
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid <= 1'b0;
         rdata  <= 32'h0;
         mem[2] <= 32'h1122_3344;
         mem[3] <= 32'h5566_7788;
         mem[5] <= 32'h1234_5678;
      end else begin
         rvalid <= req & ~stuck;
         if (req) begin
            rdata <= mem[addr];
            if (we) begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] adr, input logic w, input logic [3:0] sel,
                        input logic [31:0] dat);
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = w;
      wb.wbs_sel_i = sel;
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
   endtask

   task automatic idle_bus();
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      stuck  = 1'b0;
      rst_ni = 1'b0;
      wb.wbs_sel_i = 4'h0;
      wb.wbs_adr_i = 32'h0;
      wb.wbs_dat_i = 32'h0;
      idle_bus();
      tick();
      tick();
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
      chk("rst_dat", wb.wbs_dat_o, 32'h0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst_ni = 1'b1;
      tick();

      // read word 5
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      chk("rd_req", {31'd0, req}, 32'd1);
      chk("rd_addr", {22'd0, addr}, 32'd5);
      chk("rd_we", {31'd0, we}, 32'd0);
      chk("rd_ack_n1", {31'd0, wb.wbs_ack_o}, 32'd0);
      tick();
      chk("rd_req_n2", {31'd0, req}, 32'd0);
      chk("rd_ack_n2", {31'd0, wb.wbs_ack_o}, 32'd0);
      tick();
      chk("rd_ack_n3", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("rd_dat", wb.wbs_dat_o, 32'h1234_5678);
      idle_bus();
      tick();
      chk("rd_ack_n4", {31'd0, wb.wbs_ack_o}, 32'd0);

      // partial write to word 2
      start(32'h3000_0008, 1'b1, 4'b0011, 32'hAABB_CCDD);
      tick();
      chk("wr_req", {31'd0, req}, 32'd1);
      chk("wr_addr", {22'd0, addr}, 32'd2);
      chk("wr_we", {31'd0, we}, 32'd1);
      chk("wr_be", {28'd0, be}, 32'd3);
      chk("wr_wdata", wdata, 32'hAABB_CCDD);
      tick();
      chk("wr_ack_n2", {31'd0, wb.wbs_ack_o}, 32'd0);
      tick();
      chk("wr_ack_n3", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("wr_dat_kept", wb.wbs_dat_o, 32'h1234_5678);
      idle_bus();
      tick();
      chk("wr_mem2", mem[2], 32'h1122_CCDD);

      // zero byte-enable write to word 3
      start(32'h3000_000C, 1'b1, 4'b0000, 32'hFFFF_FFFF);
      tick();
      chk("sel0_req", {31'd0, req}, 32'd1);
      chk("sel0_be", {28'd0, be}, 32'd0);
      tick();
      tick();
      chk("sel0_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
      idle_bus();
      tick();
      chk("sel0_mem3", mem[3], 32'h5566_7788);

      // out-of-window address held for 20 cycles
      start(32'h2000_0000, 1'b0, 4'hF, 32'h0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("oow_req_ack", {30'd0, req, wb.wbs_ack_o}, 32'd0);
      end
      idle_bus();
      tick();

      // cycle abandoned during ISSUE: RAM still serviced, no ack
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      chk("drop_req", {31'd0, req}, 32'd1);
      idle_bus();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drop_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
      end

      // timeout with rvalid stuck low
      stuck = 1'b1;
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      chk("tmo_req", {31'd0, req}, 32'd1);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("tmo_ack_early", {31'd0, wb.wbs_ack_o}, 32'd0);
      end
      chk("tmo_err_early", {31'd0, err}, 32'd0);
      tick();
      chk("tmo_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("tmo_dat", wb.wbs_dat_o, 32'hDEAD_BEEF);
      chk("tmo_err", {31'd0, err}, 32'd1);
      idle_bus();
      tick();
      chk("tmo_ack_off", {31'd0, wb.wbs_ack_o}, 32'd0);
      repeat (3) tick();
      chk("tmo_err_held", {31'd0, err}, 32'd1);

      // reset pulse during WAIT
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      tick();
      rst_ni = 1'b0;
      #1;
      chk("wrst_req", {31'd0, req}, 32'd0);
      chk("wrst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
      chk("wrst_dat", wb.wbs_dat_o, 32'h0);
      chk("wrst_err", {31'd0, err}, 32'd0);
      idle_bus();
      tick();
      rst_ni = 1'b1;
      stuck  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wrst_no_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
      end
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      chk("post_rst_req", {31'd0, req}, 32'd1);
      tick();
      tick();
      chk("post_rst_ack", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("post_rst_dat", wb.wbs_dat_o, 32'h1234_5678);
      idle_bus();
      tick();

      // back-to-back reads with stb held through ACK
      start(32'h3000_0014, 1'b0, 4'hF, 32'h0);
      tick();
      chk("b2b_req1", {31'd0, req}, 32'd1);
      tick();
      tick();
      chk("b2b_ack1", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("b2b_dat1", wb.wbs_dat_o, 32'h1234_5678);
      wb.wbs_adr_i = 32'h3000_000C;
      tick();
      chk("b2b_gap", {30'd0, req, wb.wbs_ack_o}, 32'd0);
      tick();
      chk("b2b_req2", {31'd0, req}, 32'd1);
      chk("b2b_addr2", {22'd0, addr}, 32'd3);
      tick();
      chk("b2b_ack_n2", {31'd0, wb.wbs_ack_o}, 32'd0);
      tick();
      chk("b2b_ack2", {31'd0, wb.wbs_ack_o}, 32'd1);
      chk("b2b_dat2", wb.wbs_dat_o, 32'h5566_7788);
      idle_bus();
      tick();
      chk("b2b_end", {30'd0, req, wb.wbs_ack_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_ram_bridge.md
WB_RAM_BRIDGE -- requirements
Module: wb_ram_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, RAM word-address width; BASE_ADDR, default 32'h3000_0000, window base; WIN_MASK, default 32'hFFFF_F000, bits compared for window decode; TIMEOUT, default 15, maximum wait cycles for RAM rvalid.
REQ-002 One clock; reset is asynchronous and active-low. Ports: clk in 1 clock; rst_ni in 1 async active-low reset.
REQ-003 Wishbone slave ports SHALL be: wbs_cyc_i in 1, wbs_stb_i in 1, wbs_we_i in 1, wbs_sel_i in 4, wbs_adr_i in 32 (byte address), wbs_dat_i in 32, wbs_ack_o out 1, wbs_dat_o out 32.
REQ-004 RAM external-port ports SHALL be: ext_data_req_o out 1, ext_data_addr_o out ADDR_WIDTH, ext_data_we_o out 1, ext_data_be_o out 4, ext_data_wdata_o out 32, ext_data_rdata_i in 32, ext_data_rvalid_i in 1.
REQ-005 Status port SHALL be: timeout_err_o out 1, sticky flag set by any timed-out access.

Function
REQ-006 Select condition SHALL be: wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WIN_MASK) == BASE_ADDR).
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT and ACK, with IDLE as the reset state.
REQ-008 IDLE SHALL go to ISSUE on select; entering ISSUE SHALL register the address, we, sel and wdata.
REQ-009 ISSUE SHALL last exactly 1 cycle: ext_data_req_o=1, with addr=wbs_adr_i[ADDR_WIDTH+1:2], we, be=sel and wdata taken from the registered copies; next state SHALL be WAIT.
REQ-010 WAIT SHALL go to ACK when ext_data_rvalid_i=1, capturing ext_data_rdata_i into the read register for reads only.
REQ-011 In WAIT, a wait counter SHALL increment each cycle; when it reaches TIMEOUT with no rvalid, the FSM SHALL go to ACK, set the read data to 32'hDEAD_BEEF and set timeout_err_o.
REQ-012 ACK SHALL assert wbs_ack_o=1 for exactly 1 cycle with wbs_dat_o valid, then return to IDLE.
REQ-013 A new select SHALL NOT be accepted in the ACK cycle; the earliest next ISSUE is 2 cycles after ACK.
REQ-014 Nominal latency SHALL be: select in cycle N, req in N+1, rvalid in N+2, ack in N+3.
REQ-015 ext_data_req_o SHALL be asserted only in ISSUE and SHALL be 0 in all other states.
REQ-016 Writes SHALL also wait for rvalid, since the RAM returns rvalid for every request; wbs_dat_o SHALL keep its previous value on a write ack.
REQ-017 If wbs_cyc_i drops in ISSUE or WAIT, the transaction SHALL still complete to ACK, with wbs_ack_o suppressed when wbs_cyc_i=0 in that cycle.
REQ-018 An out-of-window address SHALL produce no RAM request and no ack.
REQ-019 wbs_sel_i=0 SHALL still issue a request, with be=0 and no bytes written.
REQ-020 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL clear on entering WAIT, and SHALL saturate (no wrap).
REQ-021 timeout_err_o SHALL clear only on reset.

Reset
REQ-022 Asserting rst_ni low SHALL asynchronously force: state=IDLE; ext_data_req_o=0; wbs_ack_o=0; wbs_dat_o=0; timeout_err_o=0; counter=0; all registered request fields=0.
REQ-023 Reset asserted mid-transaction SHALL abort the transaction with no ack, and req SHALL drop within the same cycle.
REQ-024 After deassertion, the first select SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (2-bit), the TIMEOUT_DATA constant 32'hDEAD_BEEF and the default BASE_ADDR and WIN_MASK.
REQ-026 One sub-module, wb_ram_bridge_timer (the saturating wait counter with a done flag), SHALL be instantiated; everything else SHALL be inline.
REQ-027 All outputs SHALL be registered except ext_data_* fields, which SHALL be driven from the registered request fields.

Verification
REQ-028 Read: preload RAM word 5 = 32'h1234_5678; WB read at adr 32'h3000_0014 -> req with addr 5 in cycle N+1, ack in N+3 with dat 32'h1234_5678.
REQ-029 Write with sel=4'b0011, dat 32'hAABB_CCDD at 32'h3000_0008 -> word 2 low half = CCDD, upper half unchanged, ack in N+3.
REQ-030 rvalid stuck low, TIMEOUT=15 -> ack exactly 15 cycles after WAIT entry, dat 32'hDEAD_BEEF, timeout_err_o=1 and held.
REQ-031 Address 32'h2000_0000 with stb held 20 cycles -> no req and no ack.
REQ-032 rst_ni pulsed low during WAIT -> ack never asserted, outputs at reset values, next read completes correctly.
REQ-033 Back-to-back reads with stb held through ACK -> second req issued 2 cycles after the first ack, with no duplicate ack.
